mean_sequencer: RTL and testbench
=================================

# mean_sequencer

Streaming front-end and scheduler for the 8-input `mean_value` unit. It accepts 16-bit samples one per handshake and assembles them into an 8-sample window. It presents the window in parallel to `mean_value` and waits out the unit's fixed pipeline latency. It then captures `y` and returns the mean on a valid/ready output, serialising all use of the shared mean datapath.

## Interface
- `MEAN_LAT`, default 1: register stages in the attached `mean_value`, meaning `y` is valid `MEAN_LAT` edges after the inputs become stable. Legal range is 1..15.
- `clk`  in  1: single clock; all state changes on the rising edge.
- `rst`  in  1: asynchronous, active-low reset.
- `s_data`  in  16: input sample.
- `s_valid`  in  1: `s_data` is valid.
- `s_ready`  out  1: the block can accept a sample.
- `mv_x`  out  128: window to `mean_value`; `[16k+15:16k]` drives `x<k>`, and `x0` is the oldest sample.
- `mv_start`  out  1: one-cycle pulse in the first cycle a complete window is presented.
- `mv_y`  in  16: `y` from `mean_value`.
- `m_data`  out  16: captured mean.
- `m_valid`  out  1: `m_data` is valid.
- `m_ready`  in  1: the consumer accepts `m_data`.
- `busy`  out  1: high whenever the state is not FILL.
- `fill_cnt`  out  4: number of samples currently in the window, 0..8.

## Operation
- **Window register:** 8×16 shift register.
  - On each accepted sample: `x0<=x1 … x6<=x7, x7<=s_data`.
  - After 8 accepts, the first sample is in `x0`.
  - `mv_x` is wired directly from this register.
- **Sample accept:** `s_valid && s_ready` at a rising edge. Gaps in `s_valid` hold `fill_cnt` and the window unchanged.
- **FSM states:** FILL, WAIT, OUT.
  - **FILL:** `s_ready=1`.
    - Each accept increments `fill_cnt`.
    - The accept that makes `fill_cnt=8` moves the FSM to WAIT and loads the latency counter with `MEAN_LAT`.
  - **WAIT:** `s_ready=0`; the window is frozen.
    - `mv_start=1` in the first WAIT cycle only.
    - The counter decrements each cycle.
    - On the edge ending the cycle in which the counter reads 0, `mv_y` is captured into `m_data` and the FSM moves to OUT.
  - **OUT:** `m_valid=1` and `s_ready=0`.
    - `m_data` is held stable until `m_valid && m_ready` at an edge.
    - After that handshake the FSM returns to FILL, with `fill_cnt` set per the Configuration section.
- **Arithmetic:** the block performs no arithmetic on sample data. The mean value is entirely `mv_y`; the block only captures it.
- **Reset (async, any state, including mid-WAIT or mid-OUT):**
  - FSM goes to FILL, `fill_cnt=0`, window register all zero.
  - Outputs: `mv_x=0`, `m_data=0`, `m_valid=0`, `mv_start=0`, `busy=0`, `s_ready=1`.
  - Any `mv_y` result still pending is discarded.
- `m_ready` is ignored outside OUT. `s_valid` is ignored outside FILL.

## Timing
- Let the 8th accept occur at edge E.
  - WAIT occupies cycles E+1 … E+1+`MEAN_LAT`, which is `MEAN_LAT+1` cycles.
  - `mv_y` is captured at the end of cycle E+1+`MEAN_LAT`.
  - `m_valid` rises in cycle E+2+`MEAN_LAT`.
- With `MEAN_LAT=1`: `mv_start` is high in cycle E+1 and `m_valid` rises in cycle E+3.
- If the consumer handshakes in the first OUT cycle, `s_ready` returns high in the following cycle.
- Peak throughput in block mode: one mean per `8+MEAN_LAT+2` cycles.
- `s_ready`, `busy` and `mv_start` are decoded from registered state. No combinational path exists from `m_ready` or `s_valid` to any output.

## Configuration
- Macro: `MEAN_SEQ_SLIDING_WINDOW_EN`.
- **Undefined (block mode):** leaving OUT sets `fill_cnt=0`. Every 8 new samples produce one mean, and windows never overlap.
- **Defined (sliding mode):**
  - Leaving OUT sets `fill_cnt=7`, and the window keeps its 7 newest samples.
  - After the first full window, each single new accept triggers WAIT/OUT for the window of the latest 8 samples.
  - Reset still clears `fill_cnt` to 0, so a full 8 samples are needed after reset.

## Test plan
The bench models `mean_value` as floor(sum/8), registered over `MEAN_LAT` stages. Default `MEAN_LAT=1` unless stated.
- **Reset:** hold `rst=0` with random inputs. Expect `m_valid=0`, `m_data=0`, `mv_x=0`, `busy=0`, `s_ready=1`, `fill_cnt=0`.
- **Block mode, back-to-back:**
  - Push 8,10,8,10,8,10,8,10. Expect `mv_start` one edge after the 8th accept and `m_valid` with `m_data=9` two edges after that; `s_ready=0` from the 8th accept until the output handshake.
  - Then push 8,12,8,12,8,12,8,12. Expect `m_data=10`.
- **Backpressure and gapped input:**
  - Insert `s_valid` gaps of 3 cycles between samples. Expect the same result, 9.
  - Hold `m_ready=0` for 5 cycles. Expect `m_valid=1`, `m_data=9` stable and `s_ready=0` for all 5 cycles.
- **Latency sweep:** with `MEAN_LAT=4`, push 8,10,…. Expect `m_valid` at E+6 and `m_data=9`.
- **Sliding mode (`MEAN_SEQ_SLIDING_WINDOW_EN` defined):**
  - After the 8,10,… window (result 9), push the single sample 16. Expect a second result `m_data=10`, from window 10,8,10,8,10,8,10,16.
  - `fill_cnt` reads 7 after each output handshake.
- **Reset mid-WAIT:**
  - Assert `rst` during WAIT. Expect `m_valid` never rises for that window and all outputs return to their reset values.
  - Then push 8,12,…. Expect `m_data=10`.

Source files
------------

// File: rtl/mean_sequencer.sv
// Collects 8 samples into a window for mean_value, waits MEAN_LAT+1 cycles, then returns y on valid/ready.
// Optional sliding-window mode is enabled by defining MEAN_SEQ_SLIDING_WINDOW_EN.
module mean_sequencer #(
  parameter int unsigned MEAN_LAT = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [15:0]  s_data,
  input  logic         s_valid,
  output logic         s_ready,
  output logic [127:0] mv_x,
  output logic         mv_start,
  input  logic [15:0]  mv_y,
  output logic [15:0]  m_data,
  output logic         m_valid,
  input  logic         m_ready,
  output logic         busy,
  output logic [3:0]   fill_cnt
);

  typedef enum logic [1:0] {FILL, WAIT, OUT} state_t;

  localparam logic [3:0] LAT_INIT = 4'(MEAN_LAT);
`ifdef MEAN_SEQ_SLIDING_WINDOW_EN
  localparam logic [3:0] REFILL_CNT = 4'd7;
`else
  localparam logic [3:0] REFILL_CNT = 4'd0;
`endif

  state_t         state_q;
  logic [3:0]     fill_q;
  logic [3:0]     lat_q;
  logic [127:0]   win_q;
  logic [15:0]    m_data_q;
  logic           start_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= FILL;
      fill_q   <= 4'd0;
      lat_q    <= 4'd0;
      win_q    <= '0;
      m_data_q <= 16'd0;
      start_q  <= 1'b0;
    end else begin
      case (state_q)
        FILL: begin
          if (s_valid) begin
            // x0 sits in the low lane, so new samples enter at the top
            win_q  <= {s_data, win_q[127:16]};
            fill_q <= fill_q + 4'd1;
            if (fill_q == 4'd7) begin
              state_q <= WAIT;
              lat_q   <= LAT_INIT;
              start_q <= 1'b1;
            end
          end
        end
        WAIT: begin
          start_q <= 1'b0;
          if (lat_q == 4'd0) begin
            m_data_q <= mv_y;
            state_q  <= OUT;
          end else begin
            lat_q <= lat_q - 4'd1;
          end
        end
        OUT: begin
          if (m_ready) begin
            state_q <= FILL;
            fill_q  <= REFILL_CNT;
          end
        end
        default: begin
          state_q <= FILL;
          start_q <= 1'b0;
        end
      endcase
    end
  end

  assign s_ready  = (state_q == FILL);
  assign busy     = (state_q != FILL);
  assign m_valid  = (state_q == OUT);
  assign mv_start = start_q;
  assign mv_x     = win_q;
  assign m_data   = m_data_q;
  assign fill_cnt = fill_q;

endmodule

// File: tb/tb_mean_sequencer.sv
// Directed bench for mean_sequencer with a floor(sum/8) mean_value model and an expected-result queue.
module tb_mean_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic [15:0]  s_data;
  logic         s_valid, s_ready;
  logic [127:0] mv_x;
  logic         mv_start;
  logic [15:0]  mv_y, m_data;
  logic         m_valid, m_ready, busy;
  logic [3:0]   fill_cnt;

  logic [15:0]  l4_s_data;
  logic         l4_s_valid, l4_s_ready;
  logic [127:0] l4_mv_x;
  logic         l4_mv_start;
  logic [15:0]  l4_mv_y, l4_m_data;
  logic         l4_m_valid, l4_m_ready, l4_busy;
  logic [3:0]   l4_fill_cnt;

  mean_sequencer #(.MEAN_LAT(1)) dut (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .mv_x(mv_x), .mv_start(mv_start), .mv_y(mv_y), .m_data(m_data), .m_valid(m_valid),
    .m_ready(m_ready), .busy(busy), .fill_cnt(fill_cnt)
  );

  mean_sequencer #(.MEAN_LAT(4)) dut_l4 (
    .clk(clk), .rst(rst), .s_data(l4_s_data), .s_valid(l4_s_valid), .s_ready(l4_s_ready),
    .mv_x(l4_mv_x), .mv_start(l4_mv_start), .mv_y(l4_mv_y), .m_data(l4_m_data), .m_valid(l4_m_valid),
    .m_ready(l4_m_ready), .busy(l4_busy), .fill_cnt(l4_fill_cnt)
  );

`ifdef MEAN_SEQ_SLIDING_WINDOW_EN
  localparam bit SLIDE = 1'b1;
`else
  localparam bit SLIDE = 1'b0;
`endif

  function automatic logic [15:0] mean8(input logic [127:0] x);
    logic [18:0] s;
    s = '0;
    for (int k = 0; k < 8; k++) s = s + 19'(x[16*k +: 16]);
    return s[18:3];
  endfunction

  // mean_value models: 1-stage and 4-stage pipelines
  logic [15:0] p1;
  logic [15:0] p4 [4];
  always @(posedge clk) begin
    p1 <= mean8(mv_x);
    p4[0] <= mean8(l4_mv_x);
    for (int i = 1; i < 4; i++) p4[i] <= p4[i-1];
  end
  assign mv_y    = p1;
  assign l4_mv_y = p4[3];

  int total = 0;
  int bad   = 0;
  logic [15:0] wq [$];
  logic [15:0] sb [$];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals();
    chk("rst_m_valid", {127'd0, m_valid}, 128'd0);
    chk("rst_m_data", {112'd0, m_data}, 128'd0);
    chk("rst_mv_x", mv_x, 128'd0);
    chk("rst_busy", {127'd0, busy}, 128'd0);
    chk("rst_s_ready", {127'd0, s_ready}, 128'd1);
    chk("rst_fill_cnt", {124'd0, fill_cnt}, 128'd0);
    chk("rst_mv_start", {127'd0, mv_start}, 128'd0);
  endtask

  task automatic push(input logic [15:0] d, input int gap);
    int w;
    logic [127:0] ew;
    bit full;
    w = 0;
    while (!s_ready && w < 64) begin @(negedge clk); w++; end
    chk("s_ready_wait", {127'd0, s_ready}, 128'd1);
    s_valid = 1'b1;
    s_data  = d;
    @(negedge clk);
    s_valid = 1'b0;
    s_data  = 16'($urandom);
    wq.push_back(d);
    chk("fill_cnt", {124'd0, fill_cnt}, 128'(wq.size()));
    full = (wq.size() == 8);
    if (full) begin
      ew = '0;
      for (int k = 0; k < 8; k++) ew[16*k +: 16] = wq[k];
      chk("mv_x", mv_x, ew);
      chk("mv_start", {127'd0, mv_start}, 128'd1);
      chk("s_ready_in_wait", {127'd0, s_ready}, 128'd0);
      chk("busy_in_wait", {127'd0, busy}, 128'd1);
      sb.push_back(mean8(ew));
      if (SLIDE) void'(wq.pop_front());
      else wq.delete();
    end
    for (int g = 0; g < gap; g++) begin
      @(negedge clk);
      if (!full) chk("gap_fill_hold", {124'd0, fill_cnt}, 128'(wq.size()));
    end
  endtask

  task automatic take(input int hold);
    int w;
    logic [15:0] e;
    w = 0;
    while (!m_valid && w < 64) begin @(negedge clk); w++; end
    chk("m_valid_wait", {127'd0, m_valid}, 128'd1);
    e = (sb.size() > 0) ? sb.pop_front() : 16'hxxxx;
    chk("m_data", {112'd0, m_data}, {112'd0, e});
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_m_valid", {127'd0, m_valid}, 128'd1);
      chk("hold_m_data", {112'd0, m_data}, {112'd0, e});
      chk("hold_s_ready", {127'd0, s_ready}, 128'd0);
    end
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
    chk("post_m_valid", {127'd0, m_valid}, 128'd0);
    chk("post_s_ready", {127'd0, s_ready}, 128'd1);
    chk("post_fill_cnt", {124'd0, fill_cnt}, SLIDE ? 128'd7 : 128'd0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    @(negedge clk);
    chk_reset_vals();
    rst = 1'b1;
    wq.delete();
    sb.delete();
    @(negedge clk);
  endtask

  initial begin
    logic [15:0] v [8];
    rst = 1'b0;
    s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
    l4_s_valid = 1'b0; l4_s_data = '0; l4_m_ready = 1'b0;

    // Reset with random activity on the inputs
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      s_valid = 1'($urandom); s_data = 16'($urandom); m_ready = 1'($urandom);
      chk_reset_vals();
    end
    s_valid = 1'b0; m_ready = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Back-to-back window with cycle-exact timing after the 8th accept
    for (int i = 0; i < 8; i++) push((i % 2) ? 16'd10 : 16'd8, 0);
    @(negedge clk);
    chk("e2_mv_start", {127'd0, mv_start}, 128'd0);
    chk("e2_m_valid", {127'd0, m_valid}, 128'd0);
    chk("e2_s_ready", {127'd0, s_ready}, 128'd0);
    @(negedge clk);
    chk("e3_m_valid", {127'd0, m_valid}, 128'd1);
    take(0);
`ifdef MEAN_SEQ_SLIDING_WINDOW_EN
    push(16'd16, 0);
    take(0);
`else
    for (int i = 0; i < 8; i++) push((i % 2) ? 16'd12 : 16'd8, 0);
    take(0);
`endif
    do_reset();

    // Gapped input and output backpressure
    for (int i = 0; i < 8; i++) push((i % 2) ? 16'd10 : 16'd8, 3);
    take(5);
    do_reset();

    // Reset in the middle of WAIT discards the pending result
    for (int i = 0; i < 8; i++) push((i % 2) ? 16'd10 : 16'd8, 0);
    rst = 1'b0;
    #1;
    chk_reset_vals();
    rst = 1'b1;
    sb.delete();
    wq.delete();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("no_valid_after_rst", {127'd0, m_valid}, 128'd0);
    end
    for (int i = 0; i < 8; i++) push((i % 2) ? 16'd12 : 16'd8, 0);
    take(0);

    // MEAN_LAT=4 instance: m_valid first seen in cycle E+6
    v = '{16'd8, 16'd10, 16'd8, 16'd10, 16'd8, 16'd10, 16'd8, 16'd10};
    l4_s_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      l4_s_data = v[i];
      @(negedge clk);
    end
    l4_s_valid = 1'b0;
    chk("l4_mv_start", {127'd0, l4_mv_start}, 128'd1);
    chk("l4_fill_cnt", {124'd0, l4_fill_cnt}, 128'd8);
    chk("l4_busy", {127'd0, l4_busy}, 128'd1);
    chk("l4_valid_e1", {127'd0, l4_m_valid}, 128'd0);
    for (int n = 2; n <= 5; n++) begin
      @(negedge clk);
      chk("l4_valid_early", {127'd0, l4_m_valid}, 128'd0);
    end
    @(negedge clk);
    chk("l4_valid_e6", {127'd0, l4_m_valid}, 128'd1);
    chk("l4_m_data", {112'd0, l4_m_data}, 128'd9);
    l4_m_ready = 1'b1;
    @(negedge clk);
    l4_m_ready = 1'b0;
    chk("l4_post_s_ready", {127'd0, l4_s_ready}, 128'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
